// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_pkg
// Description : Shared types, constants and helpers for the shift-address
//               remap table (sat_remap_table and its sub-blocks).
//               - sat_addr_t      : address type for the default table depth
//               - SAT_PEND_W      : width of the pending-swap counter
//               - sat_reset_entry : reset contents of table/inverse entry i
// Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

    localparam int SAT_DEPTH  = 8;
    localparam int SAT_AW     = $clog2(SAT_DEPTH);
    localparam int SAT_PEND_W = 4;

    typedef logic [SAT_AW-1:0] sat_addr_t;

    // The reset map swaps entries 0 and 1 so that slot 0 (the spare) starts
    // out holding physical group 1; every other entry is identity.
    function automatic int sat_reset_entry(input int i);
        if (i == 0)
            return 1;
        else if (i == 1)
            return 0;
        else
            return i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_pend_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_pend_cnt
// Description : Saturating up/down counter of queued swap requests with a
//               sticky overflow flag.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_inc       - refresh-done event (count up)
//               i_dec       - swap executed (count down); caller guarantees
//                             it is only asserted when the count is non-zero
//               o_cnt       - current pending count
//               o_ovf       - sticky, set when an increment hits saturation
// Parameters  : PEND_MAX    - saturation value, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module sat_pend_cnt
    import sat_pkg::*;
#(
    parameter int PEND_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_inc,
    input  logic                  i_dec,
    output logic [SAT_PEND_W-1:0] o_cnt,
    output logic                  o_ovf
);

    localparam logic [SAT_PEND_W-1:0] c_pend_max = SAT_PEND_W'(PEND_MAX);

    logic [SAT_PEND_W-1:0] r_cnt;
    logic                  r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc && !i_dec) begin
            // A simultaneous decrement frees a slot, so saturation only
            // applies to a lone increment.
            if (r_cnt == c_pend_max)
                r_ovf <= 1'b1;
            else
                r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sat_remap_table.sv
`default_nettype none
// ============================================================================
// Module      : sat_remap_table
// Description : Shift-address table mapping logical row groups to physical
//               ones. Each executed swap exchanges the spare slot (entry 0)
//               with entry ptr, then walks ptr down DEPTH-1..1 cyclically.
//               Refresh-done events are queued in a saturating counter and
//               executed one per cycle while hold is low.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               waddr / raddr   - logical write/read lookup addresses
//               any_ref_done    - one-cycle pulse per completed refresh
//               hold            - blocks swap execution while high
//               waddr_o/raddr_o - physical addresses, combinational lookup
//               swap_done       - registered pulse the cycle after a swap
//               pend_cnt        - queued swaps not yet executed
//               ovf             - sticky, a refresh event was dropped
//               epoch           - committed-swap count, wraps at 256
//               paddr / laddr_o - physical-to-logical lookup (optional)
// Options     : SAT_REVERSE_LUT_EN - adds the registered inverse table and
//               the paddr/laddr_o ports.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_remap_table
    import sat_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int PEND_MAX = 3,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         waddr,
    input  logic [AW-1:0]         raddr,
    input  logic                  any_ref_done,
    input  logic                  hold,
`ifdef SAT_REVERSE_LUT_EN
    input  logic [AW-1:0]         paddr,
    output logic [AW-1:0]         laddr_o,
`endif
    output logic [AW-1:0]         waddr_o,
    output logic [AW-1:0]         raddr_o,
    output logic                  swap_done,
    output logic [SAT_PEND_W-1:0] pend_cnt,
    output logic                  ovf,
    output logic [7:0]            epoch
);

    localparam logic [AW-1:0] c_ptr_first = AW'(1);
    localparam logic [AW-1:0] c_ptr_last  = AW'(DEPTH - 1);

    logic [AW-1:0]         r_sr [DEPTH];
    logic [AW-1:0]         r_ptr;
    logic [7:0]            r_epoch;
    logic                  r_swap_done;
    logic [SAT_PEND_W-1:0] w_pend_cnt;
    logic                  w_ovf;
    logic                  w_swap_fire;

    assign w_swap_fire = (w_pend_cnt != '0) && !hold;

    sat_pend_cnt #(
        .PEND_MAX (PEND_MAX)
    ) u_pend_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (any_ref_done),
        .i_dec (w_swap_fire),
        .o_cnt (w_pend_cnt),
        .o_ovf (w_ovf)
    );

    // Table, pointer and epoch. Both table writes read the pre-edge values,
    // so the exchange keeps the table a permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_sr[i] <= AW'(sat_reset_entry(i));
            r_ptr       <= c_ptr_first;
            r_epoch     <= '0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= w_swap_fire;
            if (w_swap_fire) begin
                r_sr[r_ptr] <= r_sr[0];
                r_sr[0]     <= r_sr[r_ptr];
                r_ptr       <= (r_ptr == c_ptr_first) ? c_ptr_last : r_ptr - 1'b1;
                r_epoch     <= r_epoch + 8'd1;
            end
        end
    end

`ifdef SAT_REVERSE_LUT_EN
    logic [AW-1:0] r_inv [DEPTH];

    // Physical group sr[0] moves to logical slot ptr, and sr[ptr] to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_inv[i] <= AW'(sat_reset_entry(i));
        end else if (w_swap_fire) begin
            r_inv[r_sr[0]]     <= r_ptr;
            r_inv[r_sr[r_ptr]] <= '0;
        end
    end

    assign laddr_o = r_inv[paddr];
`endif

    assign waddr_o   = r_sr[waddr];
    assign raddr_o   = r_sr[raddr];
    assign swap_done = r_swap_done;
    assign pend_cnt  = w_pend_cnt;
    assign ovf       = w_ovf;
    assign epoch     = r_epoch;

endmodule
`default_nettype wire

// File: doc/sat_remap_table.md
# sat_remap_table

Parametrised shift-address table for the GC-DRAM controller with advanced refresh. It maps logical row-group addresses to physical ones. Each completed refresh rotates one physical group through the spare slot (index 0). Refresh-done events are queued in a saturating pending counter, so swaps are deferred while the controller holds the table during an in-flight access. It sits between the command scheduler and the array address decoder and serves one write and one read lookup port per cycle.

## Interface
- DEPTH, 8, number of table entries; power of two, 4..64
- AW, $clog2(DEPTH), address width (derived, not overridable)
- PEND_MAX, 3, maximum queued swap requests; 1..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- waddr  in  AW  logical write address
- raddr  in  AW  logical read address
- any_ref_done  in  1  one-cycle pulse per completed refresh
- hold  in  1  inhibits swap execution (access in flight)
- waddr_o  out  AW  physical write address, combinational from table
- raddr_o  out  AW  physical read address, combinational from table
- swap_done  out  1  registered pulse, one cycle after a swap commits
- pend_cnt  out  4  queued swaps not yet executed
- ovf  out  1  sticky: a refresh event was dropped at saturation
- epoch  out  8  count of committed swaps, wraps at 256

## Operation
- Table sr[0..DEPTH-1] of AW-bit entries, plus swap pointer ptr (AW bits).
- Reset (synchronous): sr = {1,0,2,3,...,DEPTH-1}; ptr=1; pend_cnt=0; ovf=0; epoch=0; swap_done=0.
- The lookup outputs are pure reads: waddr_o=sr[waddr], raddr_o=sr[raddr]. During reset they show the reset table.
- swap_fire = (pend_cnt!=0) && !hold.
- On swap_fire:
  - sr[ptr] <= sr[0] and sr[0] <= sr[ptr] in the same edge.
  - ptr <= (ptr==1) ? DEPTH-1 : ptr-1. ptr never takes the value 0.
  - epoch <= epoch+1.
- Pending counter:
  - +1 on any_ref_done.
  - -1 on swap_fire.
  - Both in the same cycle: unchanged.
- Saturation: if any_ref_done arrives with pend_cnt==PEND_MAX and no swap_fire, the count stays and ovf <= 1. ovf clears only on rst.
- At most one swap per cycle. The table remains a permutation at all times.
- Reset mid-operation discards queued swaps and restores the reset table.

## Timing
- Swap commit latency from any_ref_done: 1 cycle minimum. The pulse at edge N increments pend_cnt; swap_fire is evaluated in cycle N+1 and commits at edge N+1. With hold low throughout, the lookup reflects the new map from cycle N+2.
- swap_done is high for exactly the cycle after each commit edge.
- Back-to-back ref_done pulses with hold low give one swap per cycle, after a 1-cycle lag.
- hold is sampled every cycle. Swaps resume the cycle after hold drops.
- A lookup in the same cycle as a committing swap returns the pre-swap mapping.

## Configuration
- SAT_REVERSE_LUT_EN defined:
  - Adds a registered inverse table inv[phys]=logical, updated in the same edge as each swap.
  - Adds input paddr (AW) and output laddr_o (AW) = inv[paddr], combinational.
  - Reset: inv = {1,0,2,...,DEPTH-1}.
- Undefined: no inverse table, and no paddr/laddr_o ports.

## Structure
- Shared package sat_pkg holds:
  - typedef sat_addr_t (logic [AW-1:0]) for the default DEPTH.
  - localparam SAT_PEND_W = 4.
  - function sat_reset_entry(i), returning 1 for i=0, 0 for i=1, i otherwise.
- One sub-module, sat_pend_cnt: the saturating up/down counter with a sticky overflow flag, parametrised by PEND_MAX.

## Test plan
- Reset, DEPTH=8: raddr=0 gives raddr_o=1; raddr=1 gives 0; raddr=5 gives 5; pend_cnt=0, ovf=0, epoch=0.
- One ref_done, hold=0: swap_done pulses 2 cycles later. Table becomes {0,1,2,...,7}, ptr=7, epoch=1. A second ref_done gives table {7,1,2,3,4,5,6,0}, ptr=6.
- hold=1 with 3 ref_done pulses: pend_cnt=3 and the table is unchanged. Release hold: 3 consecutive swap_done pulses, pend_cnt reaches 0.
- hold=1 with 5 pulses and PEND_MAX=3: pend_cnt=3, ovf=1 after the 4th pulse. ovf stays 1 after the queue drains.
- ref_done coinciding with swap_fire at pend_cnt=2: pend_cnt stays 2. Run 7 swaps and confirm ptr wraps 1 -> 7. Check permutation validity every cycle.
- rst asserted with pend_cnt=2: the next cycle shows the reset table, pend_cnt=0, and no swap_done. With SAT_REVERSE_LUT_EN, inv[sr[i]]==i holds every cycle.
